// File: rtl/scheduler_bitinfo_parser_if.sv
// ---------------------------------------------------------------------------
// scheduler_bitinfo_parser_if
// Bundles the parser's control handshake, status, bitinfo ROM read port and
// scheduler record write port.
//   master : the parser (drives busy/done/status, ROM address/strobe, records)
//   slave  : the environment (drives start and ROM read data)
// Signals:
//   start         parse request (single cycle)
//   busy, done    parse in progress / finished (done is a level)
//   error, err_code, num_types, num_accs   parse result
//   bitinfo_addr/en/dout                   ROM byte address, read strobe, data
//   sched_addr/en/din                      record index, write strobe, record
// ---------------------------------------------------------------------------
interface scheduler_bitinfo_parser_if #(
    parameter int MAX_ACCS      = 16,
    parameter int MAX_ACC_TYPES = 16,
    parameter int TYPE_W        = 34
);
    localparam int ACC_BITS      = $clog2(MAX_ACCS);
    localparam int TYPE_IDX_BITS = $clog2(MAX_ACC_TYPES);

    logic                         start;
    logic                         busy;
    logic                         done;
    logic                         error;
    logic [2:0]                   err_code;
    logic [TYPE_IDX_BITS:0]       num_types;
    logic [ACC_BITS:0]            num_accs;
    logic [31:0]                  bitinfo_addr;
    logic                         bitinfo_en;
    logic [31:0]                  bitinfo_dout;
    logic [TYPE_IDX_BITS-1:0]     sched_addr;
    logic                         sched_en;
    logic [TYPE_W+2*ACC_BITS-1:0] sched_din;

    modport master (
        input  start, bitinfo_dout,
        output busy, done, error, err_code, num_types, num_accs,
               bitinfo_addr, bitinfo_en, sched_addr, sched_en, sched_din
    );

    modport slave (
        output start, bitinfo_dout,
        input  busy, done, error, err_code, num_types, num_accs,
               bitinfo_addr, bitinfo_en, sched_addr, sched_en, sched_din
    );
endinterface

// File: rtl/scheduler_bitinfo_parser.sv
// ---------------------------------------------------------------------------
// scheduler_bitinfo_parser
// Walks the xtasks.config section of the bitinfo ROM, decodes each entry's
// ASCII task-type and instance-count fields and writes one scheduling record
// {task_type, count-1, first_acc_id} per accelerator type.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset; clears all state and outputs
//   bus  scheduler_bitinfo_parser_if.master (handshake, status, ROM, records)
// ---------------------------------------------------------------------------
module scheduler_bitinfo_parser #(
    parameter int MAX_ACCS      = 16,
    parameter int MAX_ACC_TYPES = 16,
    parameter int TYPE_W        = 34,
    parameter int HEADER_WORDS  = 9,
    parameter int ENTRY_WORDS   = 15,
    parameter int TYPE_DIGITS   = 19,
    parameter int INST_OFF      = 20,
    parameter int INST_DIGITS   = 3,
    parameter int RD_LAT        = 1,
    parameter int AUTO_START    = 1
) (
    input logic                          clk,
    input logic                          rst,
    scheduler_bitinfo_parser_if.master   bus
);
    localparam int ACC_BITS      = $clog2(MAX_ACCS);
    localparam int TYPE_IDX_BITS = $clog2(MAX_ACC_TYPES);
    localparam int CNT_W         = ACC_BITS + 1;
    localparam logic [7:0] SEP   = 8'h09;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT, S_CHK_END, S_TYPE_DIG, S_TYPE_SEP,
        S_INST_DIG, S_INST_SEP, S_VALIDATE, S_WRITE, S_NEXT, S_FINISH
    } state_t;

    state_t                 state_q, state_d, ret_q, ret_d;
    logic [29:0]            base_q, base_d;     // word index of current entry
    logic [29:0]            word_q, word_d;     // word index held in buf_q
    logic [29:0]            addr_q, addr_d;     // word index last fetched
    logic [31:0]            buf_q, buf_d;
    logic [7:0]             char_q, char_d;     // char position inside entry
    logic [1:0]             wait_q, wait_d;
    logic [TYPE_W-1:0]      type_q, type_d;
    logic [CNT_W-1:0]       inst_q, inst_d;
    logic [TYPE_IDX_BITS:0] ntypes_q, ntypes_d;
    logic [CNT_W-1:0]       naccs_q, naccs_d;
    logic                   err_q, err_d;
    logic [2:0]             code_q, code_d;
    logic                   done_q, done_d;
    logic                   auto_q, auto_d;

    logic [29:0]            need_word;
    logic                   word_hit;
    logic [7:0]             cur_char;
    logic [CNT_W:0]         acc_sum;
    logic [ACC_BITS-1:0]    inst_m1;

    logic                   fetch_req, fail_req;
    logic [29:0]            fetch_word;
    state_t                 fetch_ret;
    logic [2:0]             fail_code;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // acc*10 + digit as shift-add; wraps modulo 2^TYPE_W
    function automatic logic [TYPE_W-1:0] dec_type(input logic [TYPE_W-1:0] acc,
                                                   input logic [7:0] c);
        return (acc << 3) + (acc << 1) + TYPE_W'(c[3:0]);
    endfunction

    // acc*10 + digit computed wide, then saturated to all-ones
    function automatic logic [CNT_W-1:0] dec_inst(input logic [CNT_W-1:0] acc,
                                                  input logic [7:0] c);
        logic [CNT_W+3:0] w;
        w = ({4'd0, acc} << 3) + ({4'd0, acc} << 1) + (CNT_W+4)'(c[3:0]);
        if (w > (CNT_W+4)'({CNT_W{1'b1}}))
            return {CNT_W{1'b1}};
        return w[CNT_W-1:0];
    endfunction

    // char k of an entry lives in lane k%4 of entry word k/4
    assign need_word = base_q + 30'(char_q[7:2]);
    assign word_hit  = (need_word == word_q);
    assign cur_char  = buf_q[{char_q[1:0], 3'b000} +: 8];
    assign acc_sum   = {1'b0, naccs_q} + {1'b0, inst_q};
    assign inst_m1   = inst_q[ACC_BITS-1:0] - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ret_q    <= S_IDLE;
            base_q   <= '0;
            word_q   <= '0;
            addr_q   <= '0;
            buf_q    <= '0;
            char_q   <= '0;
            wait_q   <= '0;
            type_q   <= '0;
            inst_q   <= '0;
            ntypes_q <= '0;
            naccs_q  <= '0;
            err_q    <= 1'b0;
            code_q   <= '0;
            done_q   <= 1'b0;
            auto_q   <= (AUTO_START != 0);
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            base_q   <= base_d;
            word_q   <= word_d;
            addr_q   <= addr_d;
            buf_q    <= buf_d;
            char_q   <= char_d;
            wait_q   <= wait_d;
            type_q   <= type_d;
            inst_q   <= inst_d;
            ntypes_q <= ntypes_d;
            naccs_q  <= naccs_d;
            err_q    <= err_d;
            code_q   <= code_d;
            done_q   <= done_d;
            auto_q   <= auto_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        base_d     = base_q;
        word_d     = word_q;
        addr_d     = addr_q;
        buf_d      = buf_q;
        char_d     = char_q;
        wait_d     = wait_q;
        type_d     = type_q;
        inst_d     = inst_q;
        ntypes_d   = ntypes_q;
        naccs_d    = naccs_q;
        err_d      = err_q;
        code_d     = code_q;
        done_d     = done_q;
        auto_d     = auto_q;
        fetch_req  = 1'b0;
        fetch_word = need_word;
        fetch_ret  = state_q;
        fail_req   = 1'b0;
        fail_code  = 3'd0;

        case (state_q)
            S_IDLE: begin
                if (bus.start || auto_q) begin
                    auto_d     = 1'b0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    code_d     = 3'd0;
                    ntypes_d   = '0;
                    naccs_d    = '0;
                    base_d     = 30'(HEADER_WORDS);
                    char_d     = 8'd0;
                    fetch_req  = 1'b1;
                    fetch_word = 30'(HEADER_WORDS);
                    fetch_ret  = S_CHK_END;
                end
            end
            S_FETCH: begin
                wait_d  = 2'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == 2'(RD_LAT - 1)) begin
                    buf_d   = bus.bitinfo_dout;
                    word_d  = addr_q;
                    state_d = ret_q;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_CHK_END: begin
                if (buf_q == 32'hFFFF_FFFF) begin
                    state_d = S_FINISH;
                end else if (ntypes_q == (TYPE_IDX_BITS+1)'(MAX_ACC_TYPES)) begin
                    fail_req  = 1'b1;
                    fail_code = 3'd5;
                end else begin
                    type_d  = '0;
                    inst_d  = '0;
                    char_d  = 8'd0;
                    state_d = S_TYPE_DIG;
                end
            end
            S_TYPE_DIG: begin
                if (!word_hit) begin
                    fetch_req = 1'b1;
                end else if (!is_digit(cur_char)) begin
                    fail_req  = 1'b1;
                    fail_code = 3'd1;
                end else begin
                    type_d = dec_type(type_q, cur_char);
                    char_d = char_q + 8'd1;
                    if (char_q == 8'(TYPE_DIGITS - 1))
                        state_d = S_TYPE_SEP;
                end
            end
            S_TYPE_SEP: begin
                if (!word_hit) begin
                    fetch_req = 1'b1;
                end else if (cur_char != SEP) begin
                    fail_req  = 1'b1;
                    fail_code = 3'd2;
                end else begin
                    char_d  = 8'(INST_OFF);
                    state_d = S_INST_DIG;
                end
            end
            S_INST_DIG: begin
                if (!word_hit) begin
                    fetch_req = 1'b1;
                end else if (!is_digit(cur_char)) begin
                    fail_req  = 1'b1;
                    fail_code = 3'd1;
                end else begin
                    inst_d = dec_inst(inst_q, cur_char);
                    char_d = char_q + 8'd1;
                    if (char_q == 8'(INST_OFF + INST_DIGITS - 1))
                        state_d = S_INST_SEP;
                end
            end
            S_INST_SEP: begin
                if (!word_hit) begin
                    fetch_req = 1'b1;
                end else if (cur_char != SEP) begin
                    fail_req  = 1'b1;
                    fail_code = 3'd2;
                end else begin
                    state_d = S_VALIDATE;
                end
            end
            S_VALIDATE: begin
                if (inst_q == '0) begin
                    fail_req  = 1'b1;
                    fail_code = 3'd3;
                end else if (acc_sum > (CNT_W+1)'(MAX_ACCS)) begin
                    fail_req  = 1'b1;
                    fail_code = 3'd4;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = S_NEXT;
            end
            S_NEXT: begin
                ntypes_d   = ntypes_q + 1'b1;
                naccs_d    = naccs_q + inst_q;
                base_d     = base_q + 30'(ENTRY_WORDS);
                char_d     = 8'd0;
                fetch_req  = 1'b1;
                fetch_word = base_q + 30'(ENTRY_WORDS);
                fetch_ret  = S_CHK_END;
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A failed entry is abandoned: counters keep their committed values
        if (fail_req) begin
            err_d   = 1'b1;
            code_d  = fail_code;
            state_d = S_FINISH;
        end
        if (fetch_req) begin
            addr_d  = fetch_word;
            ret_d   = fetch_ret;
            wait_d  = 2'd0;
            state_d = S_FETCH;
        end
    end

    assign bus.busy         = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign bus.done         = done_q || (state_q == S_FINISH);
    assign bus.error        = err_q;
    assign bus.err_code     = code_q;
    assign bus.num_types    = ntypes_q;
    assign bus.num_accs     = naccs_q;
    assign bus.bitinfo_addr = {addr_q, 2'b00};
    assign bus.bitinfo_en   = (state_q == S_FETCH);
    assign bus.sched_en     = (state_q == S_WRITE);
    assign bus.sched_addr   = (state_q == S_WRITE) ? ntypes_q[TYPE_IDX_BITS-1:0] : '0;
    assign bus.sched_din    = (state_q == S_WRITE)
                            ? {type_q, inst_m1, naccs_q[ACC_BITS-1:0]} : '0;
endmodule
